// File: rtl/execute_stage_mc.sv
// Execute stage: single-cycle ALU plus a radix-2 restoring divider that stalls upstream.
// Optional busy-cycle performance counter enabled by EXEC_MC_PERF_EN.
module execute_stage_mc #(
  parameter int unsigned W_OPR = 32,
  parameter int unsigned W_RD  = 5,
  parameter int unsigned W_OP  = 4,
  parameter int unsigned W_CNT = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v_i,
  input  logic             stall_i,
  output logic             stall_o,
  input  logic [W_OP-1:0]  op_i,
  input  logic [W_OPR-1:0] opr0_i,
  input  logic [W_OPR-1:0] opr1_i,
  input  logic             wb_i,
  input  logic [W_RD-1:0]  wb_r_i,
  output logic             v_o,
  output logic [W_OPR-1:0] result_o,
  output logic [W_RD-1:0]  wb_r_o,
  output logic             wb_o,
  output logic [3:0]       flags_o,
`ifdef EXEC_MC_PERF_EN
  output logic [31:0]      perf_busy_o,
`endif
  output logic             busy_o
);

  localparam int unsigned LogW = $clog2(W_OPR);

  localparam logic [W_OP-1:0] OpAdd  = W_OP'(0);
  localparam logic [W_OP-1:0] OpSub  = W_OP'(1);
  localparam logic [W_OP-1:0] OpAnd  = W_OP'(2);
  localparam logic [W_OP-1:0] OpOr   = W_OP'(3);
  localparam logic [W_OP-1:0] OpXor  = W_OP'(4);
  localparam logic [W_OP-1:0] OpSll  = W_OP'(5);
  localparam logic [W_OP-1:0] OpSrl  = W_OP'(6);
  localparam logic [W_OP-1:0] OpSra  = W_OP'(7);
  localparam logic [W_OP-1:0] OpMul  = W_OP'(8);
  localparam logic [W_OP-1:0] OpDivu = W_OP'(9);
  localparam logic [W_OP-1:0] OpDivs = W_OP'(10);
  localparam logic [W_OP-1:0] OpRemu = W_OP'(11);
  localparam logic [W_OP-1:0] OpRems = W_OP'(12);
  localparam logic [W_OP-1:0] OpCmp  = W_OP'(13);

  localparam logic [W_OPR-1:0] MinVal = {1'b1, {(W_OPR-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [W_CNT-1:0]   cnt_q, cnt_d;
  logic [W_OPR-1:0]   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [W_OP-1:0]    dop_q, dop_d;
  logic               dwb_q, dwb_d, negq_q, negq_d, negr_q, negr_d, dovf_q, dovf_d;
  logic [W_RD-1:0]    dwbr_q, dwbr_d;

  logic               v_q, v_d, wb_q, wb_d;
  logic [W_OPR-1:0]   res_q, res_d;
  logic [W_RD-1:0]    wbr_q, wbr_d;
  logic [3:0]         flags_q, flags_d;

  logic               is_div, is_signed, a_neg, b_neg, div0, min_neg1;
  logic [W_OPR-1:0]   a_mag, b_mag;

  assign is_div    = (op_i >= OpDivu) && (op_i <= OpRems);
  assign is_signed = (op_i == OpDivs) || (op_i == OpRems);
  assign a_neg     = is_signed & opr0_i[W_OPR-1];
  assign b_neg     = is_signed & opr1_i[W_OPR-1];
  assign a_mag     = a_neg ? -opr0_i : opr0_i;
  assign b_mag     = b_neg ? -opr1_i : opr1_i;
  assign div0      = (opr1_i == '0);
  assign min_neg1  = (op_i == OpDivs) && (opr0_i == MinVal) && (opr1_i == '1);

  assign stall_o = stall_i || (state_q == StBusy) || ((state_q == StIdle) && v_i && is_div);

  // Single-cycle ALU; alu_val feeds the flags even when the written result is forced to zero.
  logic [W_OPR:0]     add_ext, sub_ext;
  logic [W_OPR-1:0]   alu_val, alu_res;
  logic [LogW-1:0]    sh;
  logic               alu_c, alu_v, alu_upd, alu_wb;

  assign sh = opr1_i[LogW-1:0];

  always_comb begin
    add_ext = {1'b0, opr0_i} + {1'b0, opr1_i};
    sub_ext = {1'b0, opr0_i} - {1'b0, opr1_i};
    alu_val = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_upd = 1'b1;
    alu_wb  = wb_i;
    case (op_i)
      OpAdd: begin
        alu_val = add_ext[W_OPR-1:0];
        alu_c   = add_ext[W_OPR];
        alu_v   = (opr0_i[W_OPR-1] == opr1_i[W_OPR-1]) && (alu_val[W_OPR-1] != opr0_i[W_OPR-1]);
      end
      OpSub, OpCmp: begin
        alu_val = sub_ext[W_OPR-1:0];
        alu_c   = sub_ext[W_OPR];
        alu_v   = (opr0_i[W_OPR-1] != opr1_i[W_OPR-1]) && (alu_val[W_OPR-1] != opr0_i[W_OPR-1]);
        if (op_i == OpCmp) alu_wb = 1'b0;
      end
      OpAnd: alu_val = opr0_i & opr1_i;
      OpOr:  alu_val = opr0_i | opr1_i;
      OpXor: alu_val = opr0_i ^ opr1_i;
      OpSll: alu_val = opr0_i << sh;
      OpSrl: alu_val = opr0_i >> sh;
      OpSra: alu_val = $unsigned($signed(opr0_i) >>> sh);
      OpMul: alu_val = opr0_i * opr1_i;
      default: begin
        alu_upd = 1'b0;
        alu_wb  = 1'b0;
      end
    endcase
    alu_res = (op_i == OpCmp) ? '0 : alu_val;
  end

  // One restoring step: shift next dividend bit into the partial remainder and trial-subtract.
  logic [W_OPR:0]   rem_sh, trial;
  logic [W_OPR-1:0] quo_fix, rem_fix, div_res;
  logic             is_rem_q;

  assign rem_sh   = {rem_q, quo_q[W_OPR-1]};
  assign trial    = rem_sh - {1'b0, dvs_q};
  assign quo_fix  = negq_q ? -quo_q : quo_q;
  assign rem_fix  = negr_q ? -rem_q : rem_q;
  assign is_rem_q = (dop_q == OpRemu) || (dop_q == OpRems);
  assign div_res  = is_rem_q ? rem_fix : quo_fix;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    dop_d   = dop_q;
    dwb_d   = dwb_q;
    dwbr_d  = dwbr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dovf_d  = dovf_q;
    v_d     = v_q;
    res_d   = res_q;
    wbr_d   = wbr_q;
    wb_d    = wb_q;
    flags_d = flags_q;
    unique case (state_q)
      StIdle: begin
        if (!stall_i) begin
          if (v_i && is_div) begin
            v_d    = 1'b0;
            dop_d  = op_i;
            dwb_d  = wb_i;
            dwbr_d = wb_r_i;
            if (div0) begin
              quo_d   = '1;
              rem_d   = opr0_i;
              negq_d  = 1'b0;
              negr_d  = 1'b0;
              dovf_d  = 1'b1;
              state_d = StDone;
            end else begin
              quo_d   = a_mag;
              rem_d   = '0;
              dvs_d   = b_mag;
              negq_d  = a_neg ^ b_neg;
              negr_d  = a_neg;
              dovf_d  = min_neg1;
              cnt_d   = W_CNT'(W_OPR);
              state_d = StBusy;
            end
          end else begin
            v_d   = v_i;
            res_d = alu_res;
            wbr_d = wb_r_i;
            wb_d  = alu_wb;
            if (v_i && alu_upd) begin
              flags_d = {alu_v, alu_val[W_OPR-1], (alu_val == '0), alu_c};
            end
          end
        end
      end
      StBusy: begin
        if (!trial[W_OPR]) begin
          rem_d = trial[W_OPR-1:0];
          quo_d = {quo_q[W_OPR-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[W_OPR-1:0];
          quo_d = {quo_q[W_OPR-2:0], 1'b0};
        end
        cnt_d = cnt_q - W_CNT'(1);
        if (cnt_q == W_CNT'(1)) state_d = StDone;
        if (!stall_i) v_d = 1'b0;
      end
      StDone: begin
        if (!stall_i) begin
          v_d     = 1'b1;
          res_d   = div_res;
          wbr_d   = dwbr_q;
          wb_d    = dwb_q;
          flags_d = {dovf_q, div_res[W_OPR-1], (div_res == '0), 1'b0};
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      dop_q   <= '0;
      dwb_q   <= 1'b0;
      dwbr_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dovf_q  <= 1'b0;
      v_q     <= 1'b0;
      res_q   <= '0;
      wbr_q   <= '0;
      wb_q    <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      dop_q   <= dop_d;
      dwb_q   <= dwb_d;
      dwbr_q  <= dwbr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dovf_q  <= dovf_d;
      v_q     <= v_d;
      res_q   <= res_d;
      wbr_q   <= wbr_d;
      wb_q    <= wb_d;
      flags_q <= flags_d;
    end
  end

`ifdef EXEC_MC_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else if ((state_q == StBusy) && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_busy_o = perf_q;
`endif

  assign v_o      = v_q;
  assign result_o = res_q;
  assign wb_r_o   = wbr_q;
  assign wb_o     = v_q & wb_q;
  assign flags_o  = flags_q;
  assign busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_execute_stage_mc.sv
// Randomized bench for execute_stage_mc against an arithmetic reference model.
module tb_execute_stage_mc;

  localparam int unsigned W = 32;
  localparam longint MaxS = 2147483647;
  localparam longint MinS = -MaxS - 1;
  localparam logic [31:0] MinVal = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        v_i, stall_i, stall_o, wb_i, v_o, wb_o, busy_o;
  logic [3:0]  op_i, flags_o;
  logic [31:0] opr0_i, opr1_i, result_o;
  logic [4:0]  wb_r_i, wb_r_o;
`ifdef EXEC_MC_PERF_EN
  logic [31:0] perf_busy;
`endif

  execute_stage_mc dut (
    .clk      (clk),
    .reset    (reset),
    .v_i      (v_i),
    .stall_i  (stall_i),
    .stall_o  (stall_o),
    .op_i     (op_i),
    .opr0_i   (opr0_i),
    .opr1_i   (opr1_i),
    .wb_i     (wb_i),
    .wb_r_i   (wb_r_i),
    .v_o      (v_o),
    .result_o (result_o),
    .wb_r_o   (wb_r_o),
    .wb_o     (wb_o),
    .flags_o  (flags_o),
`ifdef EXEC_MC_PERF_EN
    .perf_busy_o (perf_busy),
`endif
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the registered outputs as seen by the next stage.
  logic        exp_v = 1'b0, exp_wb = 1'b0, exp_chk = 1'b0;
  logic [31:0] exp_res = '0;
  logic [4:0]  exp_wbr = '0;
  logic [3:0]  m_flags = '0;
  logic        acc_last = 1'b0;
  logic        stall_seen = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic wb, output logic [31:0] res, output logic wb_eff,
                        output logic upd, output logic [3:0] fl, output logic chk);
    longint sa, sb, r;
    logic [31:0] val;
    logic c, v;
    sa = $signed(a);
    sb = $signed(b);
    c = 1'b0;
    v = 1'b0;
    val = '0;
    upd = 1'b1;
    wb_eff = wb;
    chk = 1'b1;
    case (op)
      4'd0: begin
        val = a + b;
        c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
        r = sa + sb;
        v = (r > MaxS) || (r < MinS);
      end
      4'd1, 4'd13: begin
        val = a - b;
        c = a < b;
        r = sa - sb;
        v = (r > MaxS) || (r < MinS);
        if (op == 4'd13) wb_eff = 1'b0;
      end
      4'd2: val = a & b;
      4'd3: val = a | b;
      4'd4: val = a ^ b;
      4'd5: val = a << b[4:0];
      4'd6: val = a >> b[4:0];
      4'd7: val = $signed(a) >>> b[4:0];
      4'd8: val = a * b;
      4'd9: begin
        if (b == 0) begin val = '1; v = 1'b1; end
        else val = a / b;
      end
      4'd10: begin
        if (b == 0) begin val = '1; v = 1'b1; end
        else if (a == MinVal && b == '1) begin val = MinVal; v = 1'b1; end
        else val = $signed(a) / $signed(b);
      end
      4'd11: begin
        if (b == 0) begin val = a; v = 1'b1; end
        else val = a % b;
      end
      4'd12: begin
        if (b == 0) begin val = a; v = 1'b1; end
        else if (a == MinVal && b == '1) val = '0;
        else val = $signed(a) % $signed(b);
      end
      default: begin
        upd = 1'b0;
        wb_eff = 1'b0;
        chk = 1'b0;
      end
    endcase
    fl = {v, val[31], (val == 0), c};
    res = (op == 4'd13) ? '0 : val;
  endtask

  // One clock: decide acceptance at the negedge, check registered outputs just after the posedge.
  task automatic cycle();
    logic acc, st, wbe, upd, chk;
    logic [31:0] r;
    logic [3:0] fl;
    logic [4:0] wbr;
    @(negedge clk);
    acc = v_i && !stall_o;
    st = stall_i;
    stall_seen = stall_o;
    wbr = wb_r_i;
    r = '0; wbe = 1'b0; upd = 1'b0; chk = 1'b0; fl = '0;
    if (acc) ref_op(op_i, opr0_i, opr1_i, wb_i, r, wbe, upd, fl, chk);
    @(posedge clk);
    #1;
    if (!st) begin
      exp_v = acc;
      if (acc) begin
        exp_res = r;
        exp_wb = wbe;
        exp_wbr = wbr;
        exp_chk = chk;
        if (upd) m_flags = fl;
      end
    end
    check_val("v_o", v_o, exp_v);
    check_val("wb_o", wb_o, exp_v & exp_wb);
    check_val("flags_o", flags_o, m_flags);
    if (exp_v) begin
      check_val("wb_r_o", wb_r_o, exp_wbr);
      if (exp_chk) check_val("result_o", result_o, exp_res);
    end
    acc_last = acc;
  endtask

  // Present one instruction and hold it until accepted; lat counts edges from presentation.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic wb, input logic [4:0] wbr, output int lat, output int nbusy);
    v_i = 1'b1; op_i = op; opr0_i = a; opr1_i = b; wb_i = wb; wb_r_i = wbr;
    lat = 0;
    nbusy = 0;
    acc_last = 1'b0;
    while (!acc_last && lat < 200) begin
      cycle();
      lat++;
      if (lat > 1 && stall_seen) nbusy++;
    end
    check_val("accepted", acc_last, 1'b1);
    v_i = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_v"}, v_o, 0);
    check_val({tag, "_res"}, result_o, 0);
    check_val({tag, "_wbr"}, wb_r_o, 0);
    check_val({tag, "_wb"}, wb_o, 0);
    check_val({tag, "_flags"}, flags_o, 0);
    check_val({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic rand_instr();
    int mode;
    op_i = 4'($urandom_range(0, 15));
    wb_i = 1'($urandom);
    wb_r_i = 5'($urandom);
    mode = $urandom_range(0, 9);
    opr0_i = $urandom;
    opr1_i = $urandom;
    if (mode < 3) begin
      opr0_i = $urandom_range(0, 300) - 150;
      opr1_i = $urandom_range(0, 20) - 10;
    end else if (mode == 3) begin
      opr1_i = '0;
    end else if (mode == 4) begin
      opr0_i = MinVal;
      opr1_i = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h1;
    end
  endtask

  int lat, nbusy;

  initial begin
    reset = 1'b0;
    v_i = 1'b0; stall_i = 1'b0; op_i = '0; opr0_i = '0; opr1_i = '0; wb_i = 1'b0; wb_r_i = '0;
    #1;
    check_reset_outs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    issue(4'd0, 32'h7FFF_FFFF, 32'h1, 1'b1, 5'd3, lat, nbusy);
    check_val("add_lat", lat, 1);
    check_val("add_res", result_o, 32'h8000_0000);
    check_val("add_wbr", wb_r_o, 3);
    check_val("add_flags", flags_o, 4'hC);

    issue(4'd13, 32'd5, 32'd7, 1'b1, 5'd4, lat, nbusy);
    check_val("cmp_wb", wb_o, 0);
    check_val("cmp_flags", flags_o, 4'h5);
    issue(4'd14, 32'd0, 32'd0, 1'b1, 5'd4, lat, nbusy);
    check_val("nop_flags", flags_o, 4'h5);

    issue(4'd9, 32'd100, 32'd7, 1'b1, 5'd7, lat, nbusy);
    check_val("divu_lat", lat - 1, W + 1);
    check_val("divu_stall", nbusy, W);
    check_val("divu_res", result_o, 14);
    cycle();
    check_val("divu_once_busy", busy_o, 0);

    issue(4'd11, 32'd100, 32'd7, 1'b1, 5'd8, lat, nbusy);
    check_val("remu_res", result_o, 2);
    issue(4'd10, -32'sd7, 32'd2, 1'b1, 5'd9, lat, nbusy);
    check_val("divs_res", result_o, 32'hFFFF_FFFD);
    issue(4'd12, -32'sd7, 32'd2, 1'b1, 5'd10, lat, nbusy);
    check_val("rems_res", result_o, 32'hFFFF_FFFF);
    issue(4'd9, 32'd9, 32'd0, 1'b1, 5'd11, lat, nbusy);
    check_val("div0_lat", lat, 2);
    check_val("div0_res", result_o, 32'hFFFF_FFFF);
    check_val("div0_v", flags_o[3], 1);

    // Reach DONE, then hold stall_i for five cycles.
    v_i = 1'b1; op_i = 4'd9; opr0_i = 32'd50; opr1_i = 32'd5; wb_i = 1'b1; wb_r_i = 5'd12;
    repeat (W + 1) cycle();
    check_val("done_busy", busy_o, 1);
    stall_i = 1'b1;
    repeat (5) begin
      cycle();
      check_val("done_hold", acc_last, 0);
    end
    stall_i = 1'b0;
    cycle();
    check_val("done_release", acc_last, 1);
    check_val("done_res", result_o, 10);
    v_i = 1'b0;
    cycle();
    check_val("no_relaunch", busy_o, 0);

    // Asynchronous reset in the middle of a divide.
    v_i = 1'b1; op_i = 4'd9; opr0_i = 32'd1000; opr1_i = 32'd3; wb_i = 1'b1; wb_r_i = 5'd13;
    repeat (6) cycle();
    #2;
    reset = 1'b0;
    v_i = 1'b0;
    #1;
    check_reset_outs("midreset");
    exp_v = 1'b0; exp_wb = 1'b0; m_flags = '0; acc_last = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    issue(4'd0, 32'd1, 32'd1, 1'b1, 5'd1, lat, nbusy);
    check_val("post_reset_add", result_o, 2);

    for (int n = 0; n < 500; n++) begin
      if (!v_i || acc_last) begin
        if ($urandom_range(0, 3) == 0) v_i = 1'b0;
        else begin
          v_i = 1'b1;
          rand_instr();
        end
      end
      stall_i = ($urandom_range(0, 5) == 0);
      cycle();
    end
    stall_i = 1'b0;
    // Let a held instruction drain before finishing.
    for (int n = 0; n < 80 && v_i; n++) begin
      cycle();
      if (acc_last) v_i = 1'b0;
    end
    check_val("drained", v_i, 0);
    cycle();
    check_val("final_busy", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/execute_stage_mc.md
Name: execute_stage_mc

Overview:
Parametrised next-generation execute stage. It sits between decode/register-read and writeback in the same slot as the current single-cycle execute stage. Single-cycle ALU ops complete in 1 cycle. Divide/remainder runs on an internal radix-2 iterative divider that back-pressures upstream via stall_o. Carries a 4-bit condition-flag register and a registered result/writeback tag to the next stage.

Parameters:
W_OPR, 32, operand/result width (>=8, even)
W_RD, 5, writeback register index width
W_OP, 4, opcode width
W_CNT, 6, divider iteration counter width; must satisfy 2^W_CNT > W_OPR

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
v_i  in  1  upstream instruction valid
stall_i  in  1  downstream stall
stall_o  out  1  stall to upstream; upstream holds all inputs while high
op_i  in  W_OP  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL (low half), 9 DIVU, 10 DIVS, 11 REMU, 12 REMS, 13 CMP; 14-15 NOP
opr0_i  in  W_OPR  operand A
opr1_i  in  W_OPR  operand B
wb_i  in  1  instruction writes a register
wb_r_i  in  W_RD  destination index
v_o  out  1  result valid
result_o  out  W_OPR  registered result
wb_r_o  out  W_RD  registered destination
wb_o  out  1  v_o & registered wb flag
flags_o  out  4  flag register: [0] carry, [1] zero, [2] sign, [3] overflow
busy_o  out  1  divider state != IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - v_o, result_o, wb_r_o, wb_o, flags_o and busy_o all 0.
  - Divider returns to IDLE and its counter clears. An in-flight divide is discarded and never produces v_o.
- Definitions:
  - is_div = op in 9..12.
  - accept = v_i & ~stall_o.
  - stall_o = stall_i | (state==BUSY) | (state==IDLE & v_i & is_div).
- Single-cycle ops:
  - When ~stall_i and state==IDLE and not is_div: v_o <= v_i; result_o, wb_r_o and the wb flag register next cycle (1-cycle latency).
  - CMP: result 0, wb forced 0, flags updated.
  - NOP: flags untouched, wb forced 0.
- Flags update only on accept for ops 0-8 and 13:
  - Z = result==0; S = result MSB.
  - ADD: C = carry out; V = signed overflow.
  - SUB/CMP: C = borrow (A<B unsigned); V = signed overflow.
  - Logic ops, shifts and MUL: C=0, V=0.
  - Shift amount = opr1_i[log2(W_OPR)-1:0].
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE->BUSY when v_i & is_div & ~stall_i. Latches operands (signed ops use magnitudes plus recorded result signs), op, wb and wb_r; counter = W_OPR.
  - While in BUSY, v_o <= 0 whenever ~stall_i (bubbles).
  - BUSY: one restoring-division step per cycle; counter decrements; at counter==1 -> DONE. Divide latency is W_OPR+1 cycles from launch to v_o.
  - Divisor 0: IDLE->DONE directly. Quotient all ones, remainder = dividend, V=1.
  - DIVS of MIN by -1: quotient = MIN, remainder 0, V=1.
  - Otherwise V=0; C=0; Z and S from the final result.
  - DONE: stall_o low. If ~stall_i: result, v_o=1, wb, wb_r and flags are registered, then -> IDLE. The upstream instruction present in this cycle is the same held divide and must not relaunch. This is guaranteed because the FSM is in DONE, not IDLE.
  - DONE with stall_i high: hold DONE and all captured values.
- stall_i high in any state: all output registers hold. The BUSY iteration continues regardless of stall_i.
- Signed fix-up:
  - Quotient negative iff operand signs differ.
  - Remainder takes the dividend's sign.

Optional Feature:
EXEC_MC_PERF_EN: adds output perf_busy_o [31:0], which counts cycles with state==BUSY. It saturates at all ones and is cleared by reset. Without the macro the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- ADD 0x7FFFFFFF + 1, wb_r=3 -> next cycle v_o=1, result 0x80000000, wb_r_o=3, flags V=1 S=1 Z=0 C=0.
- CMP 5, 7 -> v_o=1, wb_o=0, flags C=1 S=1 Z=0; a following NOP leaves flags unchanged.
- DIVU 100 / 7 issued once (upstream held) -> stall_o high for 32 cycles, v_o=1 with result 14 exactly 33 cycles after launch, one result only; REMU 100 / 7 -> 2.
- DIVS -7 / 2 -> 0xFFFFFFFD; REMS -7 / 2 -> 0xFFFFFFFF; DIVU 9 / 0 -> 0xFFFFFFFF, V=1, latency 2 cycles.
- stall_i held high for 5 cycles while in DONE -> outputs frozen, no relaunch; the result emerges on the first cycle after stall_i falls.
- Reset pulsed low mid-BUSY -> all outputs 0 immediately, busy_o=0, and the next ADD 1+1 completes normally with result 2.
